// File: rtl/grayscale_pkg.sv
// Shared definitions for the grayscale pixel pipeline: mode encodings and default weights.
package grayscale_pkg;

  typedef enum logic [1:0] {
    MODE_LUMA = 2'd0,
    MODE_AVG  = 2'd1,
    MODE_MAX  = 2'd2,
    MODE_RED  = 2'd3
  } mode_e;

  localparam int unsigned DEF_PIX_W  = 8;
  localparam int unsigned DEF_COEF_W = 4;
  localparam int unsigned DEF_FRAC   = 4;
  localparam int unsigned DEF_COEF_R = 5;
  localparam int unsigned DEF_COEF_G = 9;
  localparam int unsigned DEF_COEF_B = 2;

endpackage

// File: rtl/grayscale_pipe_rgb_weight_sum.sv
// Combinational per-mode term generation (feeds S1) and three-term adder (feeds S2).
module rgb_weight_sum
  import grayscale_pkg::*;
#(
  parameter int unsigned PIX_W  = DEF_PIX_W,
  parameter int unsigned COEF_W = DEF_COEF_W,
  parameter int unsigned COEF_R = DEF_COEF_R,
  parameter int unsigned COEF_G = DEF_COEF_G,
  parameter int unsigned COEF_B = DEF_COEF_B
) (
  input  logic [PIX_W-1:0]          r,
  input  logic [PIX_W-1:0]          g,
  input  logic [PIX_W-1:0]          b,
  input  mode_e                     mode,
  output logic [PIX_W+COEF_W-1:0]   t0,
  output logic [PIX_W+COEF_W-1:0]   t1,
  output logic [PIX_W+COEF_W-1:0]   t2,
  input  logic [PIX_W+COEF_W-1:0]   s_t0,
  input  logic [PIX_W+COEF_W-1:0]   s_t1,
  input  logic [PIX_W+COEF_W-1:0]   s_t2,
  output logic [PIX_W+COEF_W+1:0]   sum
);

  localparam int unsigned TERM_W = PIX_W + COEF_W;
  localparam int unsigned SUM_W  = TERM_W + 2;

  logic [PIX_W-1:0] mx;

  // Max/red modes place their value in t0 with t1=t2=0, so the adder passes it through.
  always_comb begin
    t0 = '0;
    t1 = '0;
    t2 = '0;
    mx = r;
    if (g > mx) mx = g;
    if (b > mx) mx = b;
    case (mode)
      MODE_LUMA: begin
        t0 = TERM_W'(r) * TERM_W'(COEF_R);
        t1 = TERM_W'(g) * TERM_W'(COEF_G);
        t2 = TERM_W'(b) * TERM_W'(COEF_B);
      end
      MODE_AVG: begin
        t0 = TERM_W'(r);
        t1 = TERM_W'(g) << 1;
        t2 = TERM_W'(b);
      end
      MODE_MAX: t0 = TERM_W'(mx);
      MODE_RED: t0 = TERM_W'(r);
      default:  t0 = '0;
    endcase
  end

  always_comb begin
    sum = SUM_W'(s_t0) + SUM_W'(s_t1) + SUM_W'(s_t2);
  end

endmodule

// File: rtl/grayscale_pipe.sv
// Three-stage RGB-to-intensity pipeline with valid/ready handshake, rounding and saturation.
module grayscale_pipe
  import grayscale_pkg::*;
#(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned COEF_W = 4,
  parameter int unsigned FRAC   = 4,
  parameter int unsigned COEF_R = 5,
  parameter int unsigned COEF_G = 9,
  parameter int unsigned COEF_B = 2,
  parameter int unsigned ROUND  = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3*PIX_W-1:0]   in_data,
  input  logic [1:0]           in_mode,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PIX_W-1:0]     out_data,
  output logic                 out_last,
  output logic [CNT_W-1:0]     pix_cnt
);

  localparam int unsigned TERM_W = PIX_W + COEF_W;
  localparam int unsigned SUM_W  = TERM_W + 2;
  localparam int unsigned Y_W    = SUM_W + 1;

  localparam logic [Y_W-1:0] RND_LUMA = (ROUND != 0 && FRAC > 0) ? (Y_W'(1) << (FRAC - 1)) : '0;
  localparam logic [Y_W-1:0] RND_AVG  = (ROUND != 0) ? Y_W'(2) : '0;
  localparam logic [Y_W-1:0] MAX_V    = {{(Y_W-PIX_W){1'b0}}, {PIX_W{1'b1}}};

  if (ROUND == 1 && FRAC < 1) begin : g_bad_frac
    $error("grayscale_pipe: FRAC must be >= 1 when ROUND=1");
  end

  logic advance;

  logic              s1_valid, s2_valid;
  mode_e             s1_mode, s2_mode;
  logic              s1_last, s2_last;
  logic [TERM_W-1:0] s1_t0, s1_t1, s1_t2;
  logic [TERM_W-1:0] t0, t1, t2;
  logic [SUM_W-1:0]  sum, s2_sum;
  logic [Y_W-1:0]    y;
  logic [PIX_W-1:0]  y_sat;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  rgb_weight_sum #(
    .PIX_W  (PIX_W),
    .COEF_W (COEF_W),
    .COEF_R (COEF_R),
    .COEF_G (COEF_G),
    .COEF_B (COEF_B)
  ) u_sum (
    .r    (in_data[PIX_W-1:0]),
    .g    (in_data[2*PIX_W-1:PIX_W]),
    .b    (in_data[3*PIX_W-1:2*PIX_W]),
    .mode (mode_e'(in_mode)),
    .t0   (t0),
    .t1   (t1),
    .t2   (t2),
    .s_t0 (s1_t0),
    .s_t1 (s1_t1),
    .s_t2 (s1_t2),
    .sum  (sum)
  );

  // S3 value before the output register; one spare bit absorbs the rounding carry.
  always_comb begin
    y = '0;
    case (s2_mode)
      MODE_LUMA: y = (Y_W'(s2_sum) + RND_LUMA) >> FRAC;
      MODE_AVG:  y = (Y_W'(s2_sum) + RND_AVG) >> 2;
      default:   y = Y_W'(s2_sum);
    endcase
    y_sat = (y > MAX_V) ? '1 : y[PIX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_mode   <= MODE_LUMA;
      s1_last   <= 1'b0;
      s1_t0     <= '0;
      s1_t1     <= '0;
      s1_t2     <= '0;
      s2_valid  <= 1'b0;
      s2_mode   <= MODE_LUMA;
      s2_last   <= 1'b0;
      s2_sum    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_mode   <= mode_e'(in_mode);
      s1_last   <= in_last;
      s1_t0     <= t0;
      s1_t1     <= t1;
      s1_t2     <= t2;
      s2_valid  <= s1_valid;
      s2_mode   <= s1_mode;
      s2_last   <= s1_last;
      s2_sum    <= sum;
      out_valid <= s2_valid;
      out_data  <= y_sat;
      out_last  <= s2_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt <= '0;
    end else if (out_valid && out_ready) begin
      pix_cnt <= pix_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_grayscale_pipe.sv
// Self-checking bench: three parameterisations driven in lockstep against an arithmetic model.
module tb_grayscale_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [23:0] in_data;
  logic [1:0]  in_mode;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_last;
  logic [7:0]  out_data;
  logic [15:0] pix_cnt;
  logic        nr_in_ready, nr_out_valid, nr_out_last;
  logic [7:0]  nr_out_data;
  logic [15:0] nr_pix_cnt;
  logic        sat_in_ready, sat_out_valid, sat_out_last;
  logic [7:0]  sat_out_data;
  logic [15:0] sat_pix_cnt;

  int errors = 0;
  int checks = 0;
  int timeouts = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int hold_viol = 0;
  int ready_viol = 0;
  bit rand_ready = 0;
  bit prev_stall = 0;
  logic [7:0] prev_data;
  logic prev_last;

  int unsigned exp_main[$], exp_nr[$], exp_sat[$], exp_last[$];
  int unsigned obs_main[$], obs_nr[$], obs_sat[$], obs_last[$];

  grayscale_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .pix_cnt(pix_cnt)
  );

  grayscale_pipe #(.ROUND(0)) dut_nr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nr_in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_last(in_last), .out_valid(nr_out_valid), .out_ready(out_ready),
    .out_data(nr_out_data), .out_last(nr_out_last), .pix_cnt(nr_pix_cnt)
  );

  grayscale_pipe #(.COEF_R(8), .COEF_G(8), .COEF_B(8)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_last(in_last), .out_valid(sat_out_valid), .out_ready(out_ready),
    .out_data(sat_out_data), .out_last(sat_out_last), .pix_cnt(sat_pix_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(negedge clk);
    if (rand_ready) out_ready = ($urandom_range(0, 1) == 1);
  end

  // Records every completed output transfer and tracks stall-hold / ready-rule behaviour.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
        hold_viol++;
      if (in_ready !== (!out_valid || out_ready)) ready_viol++;
      if (out_valid && out_ready) begin
        obs_main.push_back(out_data);
        obs_nr.push_back(nr_out_data);
        obs_sat.push_back(sat_out_data);
        obs_last.push_back(out_last);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // Intensity from the channel rules; FRAC=4 for all three instances.
  function automatic int unsigned model(int unsigned r, int unsigned g, int unsigned b,
                                        int unsigned m, int unsigned cr, int unsigned cg,
                                        int unsigned cb, int unsigned rnd);
    int unsigned y;
    case (m)
      0: y = (r*cr + g*cg + b*cb + (rnd != 0 ? 8 : 0)) / 16;
      1: y = (r + 2*g + b + (rnd != 0 ? 2 : 0)) / 4;
      2: begin y = r; if (g > y) y = g; if (b > y) y = b; end
      default: y = r;
    endcase
    if (y > 255) y = 255;
    return y;
  endfunction

  task automatic clear_q();
    exp_main.delete(); exp_nr.delete(); exp_sat.delete(); exp_last.delete();
    obs_main.delete(); obs_nr.delete(); obs_sat.delete(); obs_last.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0;
    @(negedge clk);
    rst = 0;
    clear_q();
  endtask

  task automatic send(input int unsigned r, input int unsigned g, input int unsigned b,
                      input int unsigned m, input bit last);
    int n;
    @(negedge clk);
    in_data = {8'(b), 8'(g), 8'(r)};
    in_mode = 2'(m);
    in_last = last;
    in_valid = 1;
    exp_main.push_back(model(r, g, b, m, 5, 9, 2, 1));
    exp_nr.push_back(model(r, g, b, m, 5, 9, 2, 0));
    exp_sat.push_back(model(r, g, b, m, 8, 8, 8, 1));
    exp_last.push_back(int'(last));
    #2;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk); #2; n++;
    end
    if (n >= 200) timeouts++;
    acc_cyc = cyc;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (obs_main.size() < exp_main.size() && n < 300) begin
      @(negedge clk); #3; n++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 1;
    repeat (2) @(negedge clk);
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data got=%0d exp=0", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%0b exp=0", out_last); end
    checks++; if (pix_cnt !== 16'd0) begin errors++; $display("FAIL reset_pix_cnt got=%0d exp=0", pix_cnt); end
    @(negedge clk);
    rst = 0;
    @(negedge clk); #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    clear_q();
  endtask

  task automatic test_latency();
    do_reset();
    out_ready = 1;
    @(negedge clk);
    in_data = {8'd50, 8'd100, 8'd200}; in_mode = 2'd0; in_last = 0; in_valid = 1;
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_accept got=%0b exp=1", in_ready); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      in_valid = 0;
      #2;
      checks++;
      if (out_valid !== (k == 3)) begin
        errors++; $display("FAIL lat_valid_c%0d got=%0b exp=%0b", k, out_valid, (k == 3));
      end
    end
    checks++; if (out_data !== 8'd125) begin errors++; $display("FAIL lat_data got=%0d exp=125", out_data); end
    @(negedge clk); #2;
    checks++; if (pix_cnt !== 16'd1) begin errors++; $display("FAIL lat_pix_cnt got=%0d exp=1", pix_cnt); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_single got=%0b exp=0", out_valid); end
    clear_q();
  endtask

  task automatic test_rounding();
    int unsigned em[2] = '{1, 0};
    int unsigned en[2] = '{0, 0};
    clear_q();
    out_ready = 1;
    send(0, 0, 4, 0, 0);
    send(0, 0, 3, 0, 0);
    idle();
    drain();
    checks++;
    if (obs_main.size() != 2) begin errors++; $display("FAIL rnd_count got=%0d exp=2", obs_main.size()); end
    for (int i = 0; i < 2 && i < obs_main.size(); i++) begin
      checks++; if (obs_main[i] !== em[i]) begin errors++; $display("FAIL rnd_main[%0d] got=%0d exp=%0d", i, obs_main[i], em[i]); end
      checks++; if (obs_nr[i] !== en[i]) begin errors++; $display("FAIL rnd_trunc[%0d] got=%0d exp=%0d", i, obs_nr[i], en[i]); end
    end
  endtask

  task automatic test_modes();
    int unsigned ev[4] = '{20, 200, 77, 255};
    clear_q();
    out_ready = 1;
    send(10, 20, 30, 1, 0);
    send(10, 200, 30, 2, 0);
    send(77, 0, 255, 3, 0);
    send(255, 255, 255, 0, 1);
    idle();
    drain();
    checks++;
    if (obs_main.size() != 4) begin errors++; $display("FAIL modes_count got=%0d exp=4", obs_main.size()); end
    for (int i = 0; i < 4 && i < obs_main.size(); i++) begin
      checks++; if (obs_main[i] !== ev[i]) begin errors++; $display("FAIL modes_main[%0d] got=%0d exp=%0d", i, obs_main[i], ev[i]); end
      checks++; if (obs_nr[i] !== ev[i]) begin errors++; $display("FAIL modes_trunc[%0d] got=%0d exp=%0d", i, obs_nr[i], ev[i]); end
      checks++; if (obs_sat[i] !== ev[i]) begin errors++; $display("FAIL modes_sat[%0d] got=%0d exp=%0d", i, obs_sat[i], ev[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int first_cyc;
    clear_q();
    out_ready = 1;
    for (int i = 0; i < 24; i++) begin
      send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
           i % 4, (i % 6) == 5);
      if (i == 0) first_cyc = acc_cyc;
    end
    checks++;
    if (acc_cyc - first_cyc != 23) begin errors++; $display("FAIL b2b_throughput got=%0d exp=23", acc_cyc - first_cyc); end
    idle();
    drain();
    checks++;
    if (obs_main.size() != exp_main.size()) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", obs_main.size(), exp_main.size()); end
    for (int i = 0; i < exp_main.size() && i < obs_main.size(); i++) begin
      checks++; if (obs_main[i] !== exp_main[i]) begin errors++; $display("FAIL b2b_main[%0d] got=%0d exp=%0d", i, obs_main[i], exp_main[i]); end
      checks++; if (obs_nr[i] !== exp_nr[i]) begin errors++; $display("FAIL b2b_trunc[%0d] got=%0d exp=%0d", i, obs_nr[i], exp_nr[i]); end
      checks++; if (obs_sat[i] !== exp_sat[i]) begin errors++; $display("FAIL b2b_sat[%0d] got=%0d exp=%0d", i, obs_sat[i], exp_sat[i]); end
      checks++; if (obs_last[i] !== exp_last[i]) begin errors++; $display("FAIL b2b_last[%0d] got=%0d exp=%0d", i, obs_last[i], exp_last[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    hold_viol = 0; ready_viol = 0; timeouts = 0;
    rand_ready = 1;
    for (int i = 0; i < 10; i++) begin
      send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 3), i == 9);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    drain();
    rand_ready = 0;
    @(negedge clk);
    out_ready = 1;
    #2;
    checks++; if (timeouts !== 0) begin errors++; $display("FAIL bp_timeouts got=%0d exp=0", timeouts); end
    checks++; if (hold_viol !== 0) begin errors++; $display("FAIL bp_hold got=%0d exp=0", hold_viol); end
    checks++; if (ready_viol !== 0) begin errors++; $display("FAIL bp_in_ready got=%0d exp=0", ready_viol); end
    checks++; if (pix_cnt !== 16'd10) begin errors++; $display("FAIL bp_pix_cnt got=%0d exp=10", pix_cnt); end
    checks++;
    if (obs_main.size() != 10) begin errors++; $display("FAIL bp_count got=%0d exp=10", obs_main.size()); end
    for (int i = 0; i < 10 && i < obs_main.size(); i++) begin
      checks++; if (obs_main[i] !== exp_main[i]) begin errors++; $display("FAIL bp_main[%0d] got=%0d exp=%0d", i, obs_main[i], exp_main[i]); end
      checks++; if (obs_last[i] !== exp_last[i]) begin errors++; $display("FAIL bp_last[%0d] got=%0d exp=%0d", i, obs_last[i], exp_last[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    clear_q();
    out_ready = 0;
    send(11, 22, 33, 0, 0);
    send(44, 55, 66, 1, 0);
    send(99, 10, 10, 3, 1);
    @(negedge clk);
    in_valid = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid got=%0b exp=0", out_valid); end
    checks++; if (pix_cnt !== 16'd0) begin errors++; $display("FAIL mid_pix_cnt got=%0d exp=0", pix_cnt); end
    clear_q();
    out_ready = 1;
    repeat (8) @(negedge clk);
    #3;
    checks++; if (obs_main.size() != 0) begin errors++; $display("FAIL mid_flushed got=%0d exp=0", obs_main.size()); end
    send(200, 100, 50, 0, 0);
    idle();
    drain();
    checks++;
    if (obs_main.size() != 1 || obs_main[0] !== 125) begin
      errors++; $display("FAIL mid_after got_count=%0d exp_count=1 exp=125", obs_main.size());
    end
  endtask

  initial begin
    in_valid = 0; in_data = '0; in_mode = '0; in_last = 0; out_ready = 1; rst = 1;
    test_reset();
    test_latency();
    test_rounding();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/grayscale_pipe.md
Name: grayscale_pipe

Overview:
- Parametrised, pipelined successor to the single-register grayscale converter.
- Converts packed RGB pixels to one intensity value per pixel. Four selectable modes: weighted luma, cheap average, max-channel and red-passthrough.
- Uses a valid/ready stream on both sides, with full backpressure, optional rounding and saturation.
- Sits between the pixel source (frame buffer reader) and downstream SIPU filters; carries an end-of-line sideband.

Parameters:
- PIX_W, 8: bits per colour channel and per output pixel.
- COEF_W, 4: width of each weight.
- FRAC, 4: right-shift applied to the weighted sum (weights are in units of 2^-FRAC).
- COEF_R, 5: red weight.
- COEF_G, 9: green weight.
- COEF_B, 2: blue weight.
- ROUND, 1: 1 = round-half-up before the shift; 0 = truncate.
- CNT_W, 16: width of the output pixel counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept a pixel
- in_data  in  3*PIX_W  packed pixel: r = [PIX_W-1:0], g = [2*PIX_W-1:PIX_W], b = [3*PIX_W-1:2*PIX_W]
- in_mode  in  2  mode for this pixel: 0 luma, 1 average, 2 max, 3 red
- in_last  in  1  last pixel of line
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts
- out_data  out  PIX_W  intensity
- out_last  out  1  in_last delayed with its pixel
- pix_cnt  out  CNT_W  count of completed output transfers

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; all state is cleared on the clk edge where rst=1.
- Reset values: all stage valid bits 0, out_valid=0, out_data=0, out_last=0, pix_cnt=0. in_ready=1 in the cycle after reset.
- Reset mid-operation: in-flight pixels are discarded and pix_cnt returns to 0.
- Pipeline: 3 register stages, S1 -> S2 -> S3. S3 drives the outputs. Each stage holds valid, mode, last and data.
- Latency: exactly 3 cycles from an accepted input to out_valid when out_ready stays high. Throughput is 1 pixel/clk.
- Stall rule: advance = !out_valid || out_ready. in_ready = advance (combinational).
  - When advance=1, every stage loads from its predecessor, and S1 loads in_valid && in_ready.
  - When advance=0, all stages hold.
  - Bubbles are not compressed.
- Output stability: while out_valid=1 && out_ready=0, out_data and out_last must stay stable.
- Input acceptance: a pixel is accepted on a cycle where in_valid && in_ready. in_data, in_mode and in_last are sampled only then.
- The mode travels with its pixel, so mode changes between pixels take effect per pixel with no flush.
- S1: register the channels and compute per-mode terms.
  - Mode 0 products: r*COEF_R, g*COEF_G, b*COEF_B, each PIX_W+COEF_W bits.
  - Mode 1 terms: r, 2g, b.
  - Mode 2: channel maximum.
  - Mode 3: r.
- S2: sum the terms into SUM_W = PIX_W+COEF_W+2 bits; no overflow is possible at this width.
- S3, mode 0: y = (sum + (ROUND ? 2^(FRAC-1) : 0)) >> FRAC.
- S3, mode 1: y = (sum + (ROUND ? 2 : 0)) >> 2.
- S3, modes 2/3: y = the value carried from S1.
- S3, saturation (all modes): if y > 2^PIX_W-1, out_data = 2^PIX_W-1; otherwise out_data = y[PIX_W-1:0].
- pix_cnt: increments on each out_valid && out_ready and wraps modulo 2^CNT_W. out_last has no effect on the count.
- Simultaneous events:
  - Input accept and output transfer in the same cycle are both legal and normal.
  - rst has priority over everything.
- Parameter check: FRAC >= 1 is required when ROUND=1; elaboration error otherwise.

Decomposition:
- Shared package grayscale_pkg:
  - Mode encodings MODE_LUMA=0, MODE_AVG=1, MODE_MAX=2, MODE_RED=3.
  - Default weight constants 5/9/2 and FRAC=4.
  - Function clog2 if needed.
- One sub-module, rgb_weight_sum: combinational S1 term generation and S2 adder, parameterised on PIX_W/COEF_W. The pipeline registers and handshake stay in the top module.

Test Plan:
- Defaults, mode 0, out_ready=1: r=200, g=100, b=50 -> out_data=125 exactly 3 cycles after accept; pix_cnt=1.
- Rounding, mode 0: (r,g,b)=(0,0,4) -> 1 with ROUND=1, 0 with ROUND=0; (0,0,3) -> 0 in both.
- Mode coverage: mode 1 (10,20,30) -> 20; mode 2 (10,200,30) -> 200; mode 3 (77,0,255) -> 77. Issue back-to-back with modes interleaved and check each output matches its own mode.
- Saturation: COEF_R=COEF_G=COEF_B=8, FRAC=4, (255,255,255) -> 255; defaults with (255,255,255) and ROUND=1 -> 255.
- Backpressure: stream 10 pixels with out_ready toggling randomly. Expect:
  - No loss or duplication and order preserved.
  - out_data/out_last held while stalled.
  - in_ready=0 exactly when out_valid && !out_ready.
  - Final pix_cnt=10; out_last marks the 10th pixel.
- Reset mid-stream: assert rst for 1 cycle with 3 pixels in flight -> next cycle out_valid=0 and pix_cnt=0; none of the flushed pixels ever appears.
